// File: rtl/matmul_4x4_tile_sched.sv
// matmul_4x4_tile_sched: computes a 4x4 signed C = A*B by issuing eight 2x2 tile multiplies
//   to a shared engine and accumulating each engine result into the matching C tile.
// Latency: with engine latency N, one tile takes N+2 cycles; done pulses 8N+17 cycles after start.
// Backpressure: start is only honoured in IDLE (no queueing); the engine is paced by
//   eng_start/eng_valid, with a per-tile watchdog that aborts the job and sets err on expiry.
// Ports: clk/rst (sync, active-high); start, a_in, b_in host request; busy, done, err,
//   c_out host result; eng_start, eng_a, eng_b, eng_valid, eng_c engine handshake.
module matmul_4x4_tile_sched #(
  parameter int BIT_PREC = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [BIT_PREC-1:0]   a_in [4][4],
  input  logic signed [BIT_PREC-1:0]   b_in [4][4],
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic signed [2*BIT_PREC+1:0] c_out [4][4],
  output logic                         eng_start,
  output logic signed [BIT_PREC-1:0]   eng_a [2][2],
  output logic signed [BIT_PREC-1:0]   eng_b [2][2],
  input  logic                         eng_valid,
  input  logic signed [2*BIT_PREC:0]   eng_c [2][2]
);

  localparam int CW = 2*BIT_PREC + 1;   // engine tile product width
  localparam int OW = 2*BIT_PREC + 2;   // accumulator width (sum of 4 products)
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic signed [BIT_PREC-1:0]  a_q [4][4];
  logic signed [BIT_PREC-1:0]  a_d [4][4];
  logic signed [BIT_PREC-1:0]  b_q [4][4];
  logic signed [BIT_PREC-1:0]  b_d [4][4];
  logic signed [OW-1:0]        c_q [4][4];
  logic signed [OW-1:0]        c_d [4][4];
  logic signed [CW-1:0]        ec_q [2][2];
  logic signed [CW-1:0]        ec_d [2][2];
  logic [2:0]                  tile_q, tile_d;   // {ti, tj, tk}, tk toggles fastest
  logic [TW-1:0]               wcnt_q, wcnt_d;
  logic                        err_q, err_d;
  logic                        ti, tj, tk;

  assign ti = tile_q[2];
  assign tj = tile_q[1];
  assign tk = tile_q[0];

  // Next-state logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ec_d    = ec_q;
    tile_d  = tile_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a_in;
          b_d    = b_in;
          for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
              c_d[i][j] = '0;
            end
          end
          err_d   = 1'b0;
          tile_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid) begin
          ec_d    = eng_c;
          state_d = S_ACCUM;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      S_ACCUM: begin
        // Signed cast widens the engine product by sign extension before the add.
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 2; c++) begin
            c_d[{ti, 1'(r)}][{tj, 1'(c)}] = c_q[{ti, 1'(r)}][{tj, 1'(c)}] + OW'(ec_q[r][c]);
          end
        end
        tile_d  = tile_q + 3'd1;
        state_d = (tile_q == 3'd7) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          ec_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ec_q    <= ec_d;
    end
  end

  // Outputs decode from registered state; tile operands follow the tile index, which
  // only changes when leaving ACCUM, so they stay stable for the whole tile.
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign eng_start = (state_q == S_ISSUE);
  assign err       = err_q;
  assign c_out     = c_q;

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        eng_a[r][c] = a_q[{ti, 1'(r)}][{tk, 1'(c)}];
        eng_b[r][c] = b_q[{tk, 1'(r)}][{tj, 1'(c)}];
      end
    end
  end

endmodule

// File: tb/tb_matmul_4x4_tile_sched.sv
// tb_matmul_4x4_tile_sched: bench for the 4x4 tile-scheduled matmul sequencer.
// A behavioural 2x2 engine answers eng_start after a chosen latency; jobs push the
// expected full-matrix product into a scoreboard that a monitor checks on every done.
module tb_matmul_4x4_tile_sched;

  localparam int BP = 8;
  localparam int TO = 64;
  localparam int CW = 2*BP + 1;
  localparam int OW = 2*BP + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [BP-1:0] a_in [4][4];
  logic signed [BP-1:0] b_in [4][4];
  logic busy, done, err, eng_start, eng_valid;
  logic signed [OW-1:0] c_out [4][4];
  logic signed [BP-1:0] eng_a [2][2];
  logic signed [BP-1:0] eng_b [2][2];
  logic signed [CW-1:0] eng_c [2][2];

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Current job operands, engine behaviour knobs
  int ma [4][4];
  int mb [4][4];
  int eng_mode = 0;   // 0: fixed latency, 1: random 1..5, 2: never answers
  int eng_lat  = 2;

  typedef logic [15:0][OW-1:0] cflat_t;
  cflat_t exp_c_q [$];
  bit     exp_err_q [$];
  int     exp_cyc_q [$];
  int     exp_st_q [$];

  matmul_4x4_tile_sched #(.BIT_PREC(BP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .err(err), .c_out(c_out),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_valid(eng_valid), .eng_c(eng_c)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural engine: answers N cycles after eng_start, garbage on eng_c otherwise.
  initial begin
    int  cnt;
    bit  pend;
    int  p [2][2];
    eng_valid = 1'b0;
    pend = 0;
    cnt = 0;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) eng_c[r][c] = '0;
    forever begin
      @(negedge clk);
      eng_valid = 1'b0;
      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) eng_c[r][c] = CW'($urandom);
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            eng_valid = 1'b1;
            for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) eng_c[r][c] = CW'(p[r][c]);
            pend = 0;
          end
        end
        if (eng_start && eng_mode != 2) begin
          pend = 1;
          cnt  = (eng_mode == 1) ? int'($urandom_range(1, 5)) : eng_lat;
          for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
              p[r][c] = 0;
              for (int k = 0; k < 2; k++) p[r][c] += int'(eng_a[r][k]) * int'(eng_b[k][c]);
            end
          end
        end
      end
    end
  end

  // Monitor: counts engine starts per job and checks each done against the scoreboard.
  initial begin
    int     nst;
    int     bi;
    cflat_t e;
    bit     ee;
    int     ec;
    int     es;
    nst = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nst = 0;
      end else begin
        if (eng_start) nst++;
        if (done) begin
          if (exp_c_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e  = exp_c_q.pop_front();
            ee = exp_err_q.pop_front();
            ec = exp_cyc_q.pop_front();
            es = exp_st_q.pop_front();
            bi = -1;
            for (int i = 0; i < 16; i++)
              if (bi < 0 && c_out[i/4][i%4] != $signed(e[i])) bi = i;
            if (bi < 0) bi = 0;
            chk($sformatf("c_out[%0d][%0d]", bi/4, bi%4),
                longint'(c_out[bi/4][bi%4]), longint'($signed(e[bi])));
            chk("err", longint'(err), longint'(ee));
            chk("eng_start_count", nst, es);
            if (ec >= 0) chk("done_cycle", cyc, ec);
          end
          nst = 0;
        end
      end
    end
  end

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a_in[i][j] = BP'(ma[i][j]);
        b_in[i][j] = BP'(mb[i][j]);
      end
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = int'($urandom_range(0, 255)) - 128;
        mb[i][j] = int'($urandom_range(0, 255)) - 128;
      end
    end
  endtask

  // Issue one job; exp_rel is the expected done cycle relative to start, or -1 if variable.
  task automatic run_job(input int mode, input int lat, input bit stress, input int exp_rel);
    cflat_t e;
    int     s;
    int     c0;
    int     n;
    bit     ee;
    ee = (mode == 2);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = 0;
        if (!ee) for (int k = 0; k < 4; k++) s += ma[i][k] * mb[k][j];
        e[i*4+j] = OW'(s);
      end
    end
    eng_mode = mode;
    eng_lat  = lat;
    @(negedge clk);
    drive_ops();
    start = 1'b1;
    c0 = cyc;
    exp_c_q.push_back(e);
    exp_err_q.push_back(ee);
    exp_st_q.push_back(ee ? 1 : 8);
    exp_cyc_q.push_back(exp_rel >= 0 ? c0 + exp_rel : -1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!busy || n > 3000) break;
      if (stress) begin
        // Poke start and scramble operands while busy: both must be ignored.
        start = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            a_in[i][j] = BP'($urandom);
            b_in[i][j] = BP'($urandom);
          end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (n > 3000) chk("job_timeout", n, 0);
    else if (exp_rel >= 0) chk("busy_fall_cycle", cyc, c0 + exp_rel + 1);
  endtask

  initial begin
    int n;
    int ns;
    int nz;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_eng_start", eng_start, 0);
    nz = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (c_out[i][j] != 0) nz++;
    for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++)
      if (eng_a[r][c] != 0 || eng_b[r][c] != 0) nz++;
    chk("rst_nonzero_regs", nz, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1) A = 1..16, B = identity, fixed N=2
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = i*4 + j + 1;
        mb[i][j] = (i == j) ? 1 : 0;
      end
    run_job(0, 2, 0, 33);

    // 2) all -128 * -128
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = -128; mb[i][j] = -128; end
    run_job(0, 2, 0, 33);

    // 3) all 127 * -128
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = 127; mb[i][j] = -128; end
    run_job(0, 3, 0, 8*3 + 17);

    // 4) engine never answers: abort with err at cycle 66
    rand_ops();
    run_job(2, 0, 0, 66);

    // 5) reset during WAIT of tile 3, then a fresh job
    rand_ops();
    eng_mode = 0;
    eng_lat  = 3;
    @(negedge clk);
    drive_ops();
    start = 1'b1;
    ns = 0;
    n = 0;
    while (ns < 4 && n < 500) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (eng_start) ns++;
    end
    chk("reach_tile3", ns, 4);
    @(negedge clk);             // tile 3 WAIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_eng_start", eng_start, 0);
    nz = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) if (c_out[i][j] != 0) nz++;
    chk("abort_c_out_nonzero", nz, 0);
    ns = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) ns++;
    end
    chk("abort_no_activity", ns, 0);
    rand_ops();
    run_job(0, 1, 0, 8*1 + 17);

    // 6) random operands, random latency, start pokes while busy
    for (int t = 0; t < 8; t++) begin
      rand_ops();
      run_job(1, 0, 1, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // extremes with random latency
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ma[i][j] = -128; mb[i][j] = 127; end
    run_job(1, 0, 1, -1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_c_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
